// File: rtl/transport_checksum_checker_if.sv
// AXI-Stream result channel carrying {status, checksum_pos, checksum_orig, checksum}.
interface transport_checksum_checker_if;
    logic [49:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/transport_checksum_checker.sv
// Classifies each checksum-stage result as PASS/FAIL/SKIP, queues it in a small FIFO
// behind an AXI-Stream master and keeps saturating per-class statistics.
module transport_checksum_checker #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   checksum_i,
    input  logic [15:0]                   checksum_orig_i,
    input  logic [15:0]                   checksum_pos_i,
    input  logic                          checksum_done_i,
    input  logic                          counters_clear_i,
    transport_checksum_checker_if.master  m_axis,
    output logic [CNT_WIDTH-1:0]          cnt_pass_o,
    output logic [CNT_WIDTH-1:0]          cnt_fail_o,
    output logic [CNT_WIDTH-1:0]          cnt_skip_o,
    output logic [CNT_WIDTH-1:0]          cnt_drop_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0]           ST_SKIP = 2'b00;
    localparam logic [1:0]           ST_PASS = 2'b01;
    localparam logic [1:0]           ST_FAIL = 2'b10;
    localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [49:0]          mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_pass_q, cnt_pass_d, cnt_fail_q, cnt_fail_d;
    logic [CNT_WIDTH-1:0] cnt_skip_q, cnt_skip_d, cnt_drop_q, cnt_drop_d;
    logic                 overflow_q, overflow_d;
    logic [1:0]           status;
    logic                 empty, full, pop, wr_en, drop;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        status = ST_FAIL;
        if (checksum_i == 16'd0)                 status = ST_SKIP;
        else if (checksum_i == checksum_orig_i)  status = ST_PASS;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && m_axis.tready;
    // A pop frees the head slot at the same edge, so a write into a full FIFO still fits.
    assign wr_en = checksum_done_i && (!full || pop);
    assign drop  = checksum_done_i && full && !pop;

    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = empty ? 50'd0 : mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_comb begin
        cnt_pass_d = cnt_pass_q;
        cnt_fail_d = cnt_fail_q;
        cnt_skip_d = cnt_skip_q;
        cnt_drop_d = cnt_drop_q;
        overflow_d = overflow_q;
        if (counters_clear_i) begin
            cnt_pass_d = '0;
            cnt_fail_d = '0;
            cnt_skip_d = '0;
            cnt_drop_d = '0;
            overflow_d = 1'b0;
        end else if (checksum_done_i) begin
            case (status)
                ST_PASS: cnt_pass_d = sat_inc(cnt_pass_q);
                ST_FAIL: cnt_fail_d = sat_inc(cnt_fail_q);
                default: cnt_skip_d = sat_inc(cnt_skip_q);
            endcase
            if (drop) begin
                cnt_drop_d = sat_inc(cnt_drop_q);
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_pass_q <= '0;
            cnt_fail_q <= '0;
            cnt_skip_q <= '0;
            cnt_drop_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_pass_q <= cnt_pass_d;
            cnt_fail_q <= cnt_fail_d;
            cnt_skip_q <= cnt_skip_d;
            cnt_drop_q <= cnt_drop_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; visibility is governed entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en && !rst)
            mem_q[wr_ptr_q[AW-1:0]] <= {status, checksum_pos_i, checksum_orig_i, checksum_i};
    end

    assign cnt_pass_o = cnt_pass_q;
    assign cnt_fail_o = cnt_fail_q;
    assign cnt_skip_o = cnt_skip_q;
    assign cnt_drop_o = cnt_drop_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_transport_checksum_checker.sv
// Directed bench for transport_checksum_checker (FIFO_DEPTH=4, CNT_WIDTH=4).
module tb_transport_checksum_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cs, orig, pos;
    logic        done, clr;
    logic [3:0]  c_pass, c_fail, c_skip, c_drop;
    logic        ovf;
    int          total = 0;
    int          bad   = 0;

    logic [15:0] t_cs  [7];
    logic [15:0] t_or  [7];
    logic [15:0] t_pos [7];
    logic [1:0]  t_st  [7];

    transport_checksum_checker_if axis ();

    transport_checksum_checker #(.FIFO_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .checksum_i       (cs),
        .checksum_orig_i  (orig),
        .checksum_pos_i   (pos),
        .checksum_done_i  (done),
        .counters_clear_i (clr),
        .m_axis           (axis.master),
        .cnt_pass_o       (c_pass),
        .cnt_fail_o       (c_fail),
        .cnt_skip_o       (c_skip),
        .cnt_drop_o       (c_drop),
        .overflow_o       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [49:0] ent(input logic [1:0] st, input logic [15:0] p,
                                        input logic [15:0] o, input logic [15:0] c);
        return {st, p, o, c};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] c, input logic [15:0] o, input logic [15:0] p);
        cs = c; orig = o; pos = p; done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        t_cs[0] = 16'h1111; t_or[0] = 16'h1111; t_pos[0] = 16'd10; t_st[0] = 2'b01;
        t_cs[1] = 16'h2222; t_or[1] = 16'h2223; t_pos[1] = 16'd11; t_st[1] = 2'b10;
        t_cs[2] = 16'h0000; t_or[2] = 16'h3333; t_pos[2] = 16'd12; t_st[2] = 2'b00;
        t_cs[3] = 16'h4444; t_or[3] = 16'h4444; t_pos[3] = 16'd13; t_st[3] = 2'b01;
        t_cs[4] = 16'h5555; t_or[4] = 16'h5555; t_pos[4] = 16'd14; t_st[4] = 2'b01;
        t_cs[5] = 16'h0000; t_or[5] = 16'h0001; t_pos[5] = 16'd15; t_st[5] = 2'b00;
        t_cs[6] = 16'h6666; t_or[6] = 16'h6666; t_pos[6] = 16'd16; t_st[6] = 2'b01;

        rst = 1'b1; cs = '0; orig = '0; pos = '0; done = 1'b0; clr = 1'b0;
        axis.tready = 1'b0;
        step(); step();
        check("rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("rst_tdata",  64'(axis.tdata),  64'd0);
        check("rst_pass",   64'(c_pass), 64'd0);
        check("rst_drop",   64'(c_drop), 64'd0);
        check("rst_ovf",    64'(ovf),    64'd0);
        rst = 1'b0;
        step();

        // Test 1: PASS frame, latency 1
        axis.tready = 1'b1;
        send(16'h1C46, 16'h1C46, 16'd51);
        check("t1_tvalid", 64'(axis.tvalid), 64'd1);
        check("t1_tdata",  64'(axis.tdata),  64'(ent(2'b01, 16'd51, 16'h1C46, 16'h1C46)));
        check("t1_pass",   64'(c_pass), 64'd1);
        step();
        check("t1_drained", 64'(axis.tvalid), 64'd0);

        // Test 2: FAIL then SKIP
        send(16'h1C46, 16'h1C47, 16'd7);
        check("t2_fail_tdata", 64'(axis.tdata), 64'(ent(2'b10, 16'd7, 16'h1C47, 16'h1C46)));
        check("t2_fail_cnt",   64'(c_fail), 64'd1);
        step();
        send(16'h0000, 16'hBEEF, 16'd9);
        check("t2_skip_tdata", 64'(axis.tdata), 64'(ent(2'b00, 16'd9, 16'hBEEF, 16'h0000)));
        check("t2_skip_cnt",   64'(c_skip), 64'd1);
        step();
        check("t2_drained", 64'(axis.tvalid), 64'd0);

        // Test 3: overfill with tready low
        clr = 1'b1; step(); clr = 1'b0;
        check("t3_cleared", 64'(c_pass), 64'd0);
        axis.tready = 1'b0;
        for (int i = 0; i < 6; i++) send(t_cs[i], t_or[i], t_pos[i]);
        check("t3_pass", 64'(c_pass), 64'd3);
        check("t3_fail", 64'(c_fail), 64'd1);
        check("t3_skip", 64'(c_skip), 64'd2);
        check("t3_drop", 64'(c_drop), 64'd2);
        check("t3_ovf",  64'(ovf),    64'd1);
        check("t3_sum",  64'(c_pass) + 64'(c_fail) + 64'(c_skip), 64'd6);
        step();
        check("t3_hold_tvalid", 64'(axis.tvalid), 64'd1);
        check("t3_hold_head", 64'(axis.tdata), 64'(ent(t_st[0], t_pos[0], t_or[0], t_cs[0])));

        // Test 4: full, write and pop in the same cycle
        axis.tready = 1'b1;
        check("t4_popped_oldest", 64'(axis.tdata), 64'(ent(t_st[0], t_pos[0], t_or[0], t_cs[0])));
        send(t_cs[6], t_or[6], t_pos[6]);
        check("t4_no_drop", 64'(c_drop), 64'd2);
        check("t4_head1", 64'(axis.tdata), 64'(ent(t_st[1], t_pos[1], t_or[1], t_cs[1])));
        step();
        check("t4_head2", 64'(axis.tdata), 64'(ent(t_st[2], t_pos[2], t_or[2], t_cs[2])));
        step();
        check("t4_head3", 64'(axis.tdata), 64'(ent(t_st[3], t_pos[3], t_or[3], t_cs[3])));
        step();
        check("t4_head6", 64'(axis.tdata), 64'(ent(t_st[6], t_pos[6], t_or[6], t_cs[6])));
        step();
        check("t4_empty", 64'(axis.tvalid), 64'd0);

        // Test 5: saturation and clear-with-done
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 20; i++) send(16'hA5A5, 16'hA5A5, 16'(i));
        check("t5_sat", 64'(c_pass), 64'd15);
        check("t5_drop0", 64'(c_drop), 64'd0);
        clr = 1'b1;
        send(16'h1234, 16'h1234, 16'd77);
        clr = 1'b0;
        check("t5_clr_wins", 64'(c_pass), 64'd0);
        check("t5_fifo_kept", 64'(axis.tdata), 64'(ent(2'b01, 16'd77, 16'h1234, 16'h1234)));
        step();
        check("t5_drained", 64'(axis.tvalid), 64'd0);

        // Test 6: asynchronous reset mid-operation
        axis.tready = 1'b0;
        for (int i = 0; i < 3; i++) send(t_cs[i], t_or[i], t_pos[i]);
        check("t6_pre_tvalid", 64'(axis.tvalid), 64'd1);
        check("t6_pre_pass",   64'(c_pass), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_tvalid", 64'(axis.tvalid), 64'd0);
        check("t6_async_tdata",  64'(axis.tdata),  64'd0);
        send(16'h7777, 16'h7777, 16'd5);
        rst = 1'b0;
        step();
        check("t6_post_tvalid", 64'(axis.tvalid), 64'd0);
        check("t6_post_pass",   64'(c_pass), 64'd0);
        check("t6_post_fail",   64'(c_fail), 64'd0);
        check("t6_post_skip",   64'(c_skip), 64'd0);
        check("t6_post_ovf",    64'(ovf),    64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
